// File: rtl/noc_pkg.sv
// Shared NoC definitions: allocator FSM states and default port sizing.
package noc_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } vc_state_e;

  localparam int FIFO_NUM_DEF     = 5;
  localparam int CREDIT_DEPTH_DEF = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set req bit at or after ptr,
// scanning upward and wrapping. Returns a one-hot grant, its index, and any.
module rr_pick #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int          j;
    logic [IW-1:0] w_j;
    gnt = '0;
    idx = ptr;
    any = 1'b0;
    for (int off = 0; off < N; off++) begin
      j = int'(ptr) + off;
      if (j >= N) j = j - N;
      w_j = IW'(j);
      if (!any && req[w_j]) begin
        any      = 1'b1;
        gnt[w_j] = 1'b1;
        idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/vc_sched.sv
// Wormhole VC scheduler with per-VC credit counters and a round-robin head
// arbiter. Optional stall statistics counter under VC_SCHED_STATS_EN.
module vc_sched
  import noc_pkg::*;
#(
  parameter int FIFO_NUM     = FIFO_NUM_DEF,
  parameter int CREDIT_DEPTH = CREDIT_DEPTH_DEF,
  parameter int IW           = (FIFO_NUM > 1) ? $clog2(FIFO_NUM) : 1,
  parameter int CW           = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FIFO_NUM-1:0] vc_valid,
  input  logic [FIFO_NUM-1:0] vc_head,
  input  logic [FIFO_NUM-1:0] vc_tail,
  input  logic [FIFO_NUM-1:0] credit_in,
  input  logic                out_ready,
  output logic [FIFO_NUM-1:0] rd_en,
  output logic [IW-1:0]       grant_idx,
  output logic                grant_valid,
  output logic                credit_err
`ifdef VC_SCHED_STATS_EN
  , output logic [15:0]       stall_cnt
`endif
);

  vc_state_e             r_state;
  logic [IW-1:0]         r_rr;
  logic [IW-1:0]         r_lock;
  logic                  r_err;

  logic [FIFO_NUM-1:0]   w_cnz;
  logic [FIFO_NUM-1:0]   w_err;
  logic [FIFO_NUM-1:0]   w_elig;
  logic [FIFO_NUM-1:0]   w_pick_gnt;
  logic [IW-1:0]         w_pick_idx;
  logic                  w_pick_any;
  logic                  w_go;
  logic [IW-1:0]         w_sel;
  logic [FIFO_NUM-1:0]   w_lock_oh;

  assign w_elig    = vc_valid & w_cnz;
  assign w_lock_oh = {{(FIFO_NUM-1){1'b0}}, 1'b1} << r_lock;

  rr_pick #(.N(FIFO_NUM), .IW(IW)) u_pick (
    .req (w_elig & vc_head),
    .ptr (r_rr),
    .gnt (w_pick_gnt),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  // Reset gates the grant so outputs drop the instant rst falls.
  always_comb begin
    if (r_state == LOCKED) begin
      w_go  = rst & out_ready & w_elig[r_lock];
      w_sel = r_lock;
      rd_en = w_go ? w_lock_oh : '0;
    end else begin
      w_go  = rst & out_ready & w_pick_any;
      w_sel = w_go ? w_pick_idx : r_rr;
      rd_en = w_go ? w_pick_gnt : '0;
    end
  end

  assign grant_valid = w_go;
  assign grant_idx   = w_sel;
  assign credit_err  = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_rr    <= '0;
      r_lock  <= '0;
    end else if (w_go) begin
      if (r_state == LOCKED) begin
        if (vc_tail[r_lock]) begin
          r_state <= IDLE;
          r_rr    <= (r_lock == IW'(FIFO_NUM-1)) ? '0 : r_lock + 1'b1;
        end
      end else if (vc_tail[w_pick_idx]) begin
        r_rr <= (w_pick_idx == IW'(FIFO_NUM-1)) ? '0 : w_pick_idx + 1'b1;
      end else begin
        r_state <= LOCKED;
        r_lock  <= w_pick_idx;
      end
    end
  end

  // Per-VC credit counters; a pop and a returned credit in the same cycle cancel.
  for (genvar i = 0; i < FIFO_NUM; i++) begin : g_cred
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        r_cnt <= CW'(CREDIT_DEPTH);
      else if (rd_en[i] && !credit_in[i])
        r_cnt <= r_cnt - 1'b1;
      else if (!rd_en[i] && credit_in[i] && (r_cnt != CW'(CREDIT_DEPTH)))
        r_cnt <= r_cnt + 1'b1;
    end
    assign w_cnz[i] = |r_cnt;
    assign w_err[i] = credit_in[i] & ~rd_en[i] & (r_cnt == CW'(CREDIT_DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else      r_err <= r_err | (|w_err);
  end

`ifdef VC_SCHED_STATS_EN
  logic [15:0] r_stall;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_stall <= '0;
    else if ((|vc_valid) && !w_go && (r_stall != 16'hFFFF))
      r_stall <= r_stall + 16'd1;
  end
  assign stall_cnt = r_stall;
`endif

endmodule
